game_over_overlay_ctrl: RTL and testbench
=========================================

Name: game_over_overlay_ctrl

Overview:
- Sequences the game-over image datapath (sync image ROM -> 16-entry palette -> pixel mux) for the VGA pixel stream.
- Computes the ROM address from the draw coordinates and aligns ROM and palette latency with the background pixel.
- Runs a per-frame fade-in/fade-out state machine and blends palette colour over the background.
- Sits between the VGA controller/background renderer and the final RGB output registers.

Parameters:
- IMG_W, 240, image width in pixels
- IMG_H, 120, image height in pixels
- X0, 200, left screen column of the image window
- Y0, 180, top screen row of the image window
- ADDR_W, 15, ROM address width; must satisfy IMG_W*IMG_H <= 2**ADDR_W
- FADE_FRAMES, 2, frames per fade step (>=1)
- TRANSP_IDX, 0, palette index treated as transparent (optional feature only)

Ports:
- Clk  in  1  pixel-domain clock
- Reset_n  in  1  synchronous active-low reset
- game_over  in  1  level; request overlay shown
- restart  in  1  single-cycle pulse; request overlay hidden
- vs  in  1  VGA vertical sync; frame tick = registered rising edge
- active_video  in  1  high while the current pixel is displayable
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- bg_red, bg_green, bg_blue  in  4 each  background colour for DrawX/DrawY (same cycle)
- rom_addr  out  ADDR_W  image ROM address, registered
- rom_q  in  4  ROM data; valid 1 cycle after rom_addr
- pal_index  out  4  palette index (= rom_q, combinational)
- pal_red, pal_green, pal_blue  in  4 each  palette output (combinational from pal_index)
- red, green, blue  out  4 each  final pixel, registered
- overlay_active  out  1  state != HIDDEN
- fade_level  out  5  current blend level, 0..16

Behaviour:
- Reset (Clk edge with Reset_n=0): state HIDDEN, fade_level 0, rom_addr 0, RGB 0, all pipeline valid/window/bg registers cleared, vs edge register cleared. Reset mid-fade aborts immediately.
- Pipeline latency is 3 cycles from DrawX/DrawY/bg_* to red/green/blue:
  - S1 registers in_win, rom_addr, bg, active_video.
  - S2 registers the delayed bg/in_win/active_video while the ROM read completes.
  - S3 registers the blend result.
- in_win: X0 <= DrawX < X0+IMG_W and Y0 <= DrawY < Y0+IMG_H.
- rom_addr = (DrawY-Y0)*IMG_W + (DrawX-X0), truncated to ADDR_W; rom_addr = 0 when !in_win.
- Blend per channel: out = (pal*L + bg*(16-L)) >> 4, with L = fade_level. Intermediate is 9 bits; result is at most 15 and never overflows.
- Output selection:
  - delayed active_video=0 -> RGB 0
  - !in_win -> bg
  - otherwise -> blend
- FSM states and transitions (fade_level changes only on frame tick, never mid-frame):
  - HIDDEN: game_over=1 -> FADE_IN.
  - FADE_IN: every FADE_FRAMES ticks L++; L reaching 16 -> SHOWN.
  - SHOWN: L=16; restart -> FADE_OUT.
  - FADE_OUT: every FADE_FRAMES ticks L--; L reaching 0 -> HIDDEN.
  - restart in FADE_IN -> FADE_OUT from current L.
  - game_over=1 in FADE_OUT -> FADE_IN from current L.
  - restart and game_over in the same cycle: restart wins.
  - game_over still high in HIDDEN after a fade-out re-enters FADE_IN only on a fresh 0->1 edge.
- Frame-step counter resets to 0 on every state change.
- L saturates at 0 and 16.

Optional Feature:
- Macro: GAME_OVER_OVERLAY_TRANSPARENCY_EN.
- Defined: a window pixel whose rom_q == TRANSP_IDX outputs bg regardless of L.
- Undefined: every window pixel is blended; TRANSP_IDX is ignored.

Decomposition:
- Package game_over_pkg holds:
  - enum ovl_state_t {HIDDEN, FADE_IN, SHOWN, FADE_OUT}
  - LEVEL_W=5, LEVEL_MAX=16
  - a 12-bit rgb12_t struct
- Sub-module fade_blend_ch: combinational 4-bit blend of one channel, instanced 3 times.
- The palette stays external.

Test Plan:
- Reset: hold Reset_n=0 for 4 cycles mid-stream -> RGB=0, fade_level=0, overlay_active=0, rom_addr=0. Repeat at L=7 in FADE_IN -> same result.
- Fade-in: FADE_FRAMES=1, game_over=1, 16 vs rising edges -> fade_level steps 1..16, one per edge; state SHOWN after the 16th.
- Address/latency: DrawX=X0+3, DrawY=Y0+1 -> rom_addr=243 next cycle. With pal=F,F,F, bg=0,0,0, L=16 -> RGB F,F,F exactly 3 cycles after the input. At L=8 -> 7,7,7.
- Window edge: DrawX=X0+IMG_W, bg=A,5,3, L=16 -> RGB A,5,3 and rom_addr=0. With active_video=0 -> RGB 0,0,0.
- Reversal: restart at L=5 in FADE_IN -> FADE_OUT; L=0 and HIDDEN after 5 ticks. restart+game_over in the same cycle while SHOWN -> FADE_OUT.
- With GAME_OVER_OVERLAY_TRANSPARENCY_EN: rom_q=TRANSP_IDX, L=16, bg=2,4,6 -> RGB 2,4,6. Without the macro -> palette entry 0 colour.

Source files
------------

// File: rtl/game_over_overlay_ctrl_pkg.sv
// Shared types and constants for the game-over overlay controller.
package game_over_pkg;

  typedef enum logic [1:0] {HIDDEN, FADE_IN, SHOWN, FADE_OUT} ovl_state_t;

  localparam int LEVEL_W   = 5;
  localparam int LEVEL_MAX = 16;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Saturating one-step move of the blend level within 0..LEVEL_MAX.
  function automatic logic [LEVEL_W-1:0] level_step(input logic [LEVEL_W-1:0] lvl,
                                                    input logic up);
    if (up) return (lvl >= LEVEL_W'(LEVEL_MAX)) ? LEVEL_W'(LEVEL_MAX) : lvl + 1'b1;
    return (lvl == '0) ? '0 : lvl - 1'b1;
  endfunction

endpackage

// File: rtl/game_over_overlay_ctrl_fade_blend_ch.sv
// One colour channel of the overlay blend: (pal*L + bg*(16-L)) >> 4.
module fade_blend_ch
  import game_over_pkg::*;
(
  input  logic [3:0]         pal,
  input  logic [3:0]         bg,
  input  logic [LEVEL_W-1:0] level,
  output logic [3:0]         out
);

  logic [8:0] sum;

  // Weights always add to 16, so the sum tops out at 240 and fits in 8 bits.
  assign sum = 9'(pal) * 9'(level) + 9'(bg) * 9'(LEVEL_W'(LEVEL_MAX) - level);
  assign out = 4'(sum >> 4);

endmodule

// File: rtl/game_over_overlay_ctrl.sv
// Game-over overlay: ROM addressing, 3-stage pixel pipeline and per-frame fade FSM.
// Optional macro GAME_OVER_OVERLAY_TRANSPARENCY_EN makes palette index TRANSP_IDX show background.
//
// state    | meaning
// HIDDEN   | overlay off, level 0
// FADE_IN  | level rises one step every FADE_FRAMES frames
// SHOWN    | overlay fully opaque, level 16
// FADE_OUT | level falls one step every FADE_FRAMES frames
module game_over_overlay_ctrl
  import game_over_pkg::*;
#(
  parameter int IMG_W       = 240,
  parameter int IMG_H       = 120,
  parameter int X0          = 200,
  parameter int Y0          = 180,
  parameter int ADDR_W      = 15,
  parameter int FADE_FRAMES = 2,
  parameter int TRANSP_IDX  = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              game_over,
  input  logic              restart,
  input  logic              vs,
  input  logic              active_video,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              overlay_active,
  output logic [4:0]        fade_level
);

`ifdef GAME_OVER_OVERLAY_TRANSPARENCY_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  localparam int CNT_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_FRAMES - 1);

  ovl_state_t         state, state_nx;
  logic [LEVEL_W-1:0] level, level_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               vs_q, go_q, tick, go_rise, frame_done;

  assign tick       = vs & ~vs_q;
  assign go_rise    = game_over & ~go_q;
  assign frame_done = tick && (cnt == CNT_LAST);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= HIDDEN;
      level <= '0;
      cnt   <= '0;
      vs_q  <= 1'b0;
      go_q  <= 1'b0;
    end else begin
      state <= state_nx;
      level <= level_nx;
      cnt   <= cnt_nx;
      vs_q  <= vs;
      go_q  <= game_over;
    end
  end

  always_comb begin
    state_nx = state;
    level_nx = level;
    cnt_nx   = cnt;
    unique case (state)
      HIDDEN: begin
        // Edge-qualified so a level still held after fade-out does not re-trigger.
        if (go_rise && !restart) begin
          state_nx = FADE_IN;
          cnt_nx   = '0;
        end
      end
      FADE_IN: begin
        if (restart) begin
          state_nx = FADE_OUT;
          cnt_nx   = '0;
        end else if (tick) begin
          cnt_nx = frame_done ? '0 : cnt + CNT_W'(1);
          if (frame_done) begin
            level_nx = level_step(level, 1'b1);
            if (level_step(level, 1'b1) == LEVEL_W'(LEVEL_MAX)) state_nx = SHOWN;
          end
        end
      end
      SHOWN: begin
        level_nx = LEVEL_W'(LEVEL_MAX);
        if (restart) begin
          state_nx = FADE_OUT;
          cnt_nx   = '0;
        end
      end
      FADE_OUT: begin
        if (game_over && !restart) begin
          state_nx = FADE_IN;
          cnt_nx   = '0;
        end else if (tick) begin
          cnt_nx = frame_done ? '0 : cnt + CNT_W'(1);
          if (frame_done) begin
            level_nx = level_step(level, 1'b0);
            if (level_step(level, 1'b0) == '0) begin
              state_nx = HIDDEN;
              cnt_nx   = '0;
            end
          end
        end
      end
      default: state_nx = HIDDEN;
    endcase
  end

  assign overlay_active = (state != HIDDEN);
  assign fade_level     = level;

  logic              in_win, win1, win2, av1, av2;
  logic [ADDR_W-1:0] dx, dy, addr_calc;
  rgb12_t            bg_in, bg1, bg2, blend, px_nx, rgb_q;
  logic [3:0]        blend_r, blend_g, blend_b;
  logic              transp_hit;

  assign in_win = ({1'b0, DrawX} >= 11'(X0)) && ({1'b0, DrawX} < 11'(X0 + IMG_W)) &&
                  ({1'b0, DrawY} >= 11'(Y0)) && ({1'b0, DrawY} < 11'(Y0 + IMG_H));
  assign dx        = ADDR_W'(DrawX - 10'(X0));
  assign dy        = ADDR_W'(DrawY - 10'(Y0));
  assign addr_calc = dy * ADDR_W'(IMG_W) + dx;
  assign bg_in     = '{r: bg_red, g: bg_green, b: bg_blue};
  assign pal_index = rom_q;

  fade_blend_ch u_blend_r (.pal(pal_red),   .bg(bg2.r), .level(level), .out(blend_r));
  fade_blend_ch u_blend_g (.pal(pal_green), .bg(bg2.g), .level(level), .out(blend_g));
  fade_blend_ch u_blend_b (.pal(pal_blue),  .bg(bg2.b), .level(level), .out(blend_b));

  assign blend      = '{r: blend_r, g: blend_g, b: blend_b};
  assign transp_hit = TRANSP_EN && (pal_index == 4'(TRANSP_IDX));

  always_comb begin
    px_nx = blend;
    if (!av2)                    px_nx = '0;
    else if (!win2 || transp_hit) px_nx = bg2;
  end

  // S1 issues the ROM read, S2 waits on it, S3 registers the final pixel.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      win1     <= 1'b0;
      av1      <= 1'b0;
      bg1      <= '0;
      win2     <= 1'b0;
      av2      <= 1'b0;
      bg2      <= '0;
      rgb_q    <= '0;
    end else begin
      rom_addr <= in_win ? addr_calc : '0;
      win1     <= in_win;
      av1      <= active_video;
      bg1      <= bg_in;
      win2     <= win1;
      av2      <= av1;
      bg2      <= bg1;
      rgb_q    <= px_nx;
    end
  end

  assign red   = rgb_q.r;
  assign green = rgb_q.g;
  assign blue  = rgb_q.b;

endmodule

// File: tb/tb_game_over_overlay_ctrl.sv
// Scoreboard bench for game_over_overlay_ctrl: stimulus queues expectations, a monitor checks them.
module tb_game_over_overlay_ctrl;

  localparam int X0 = 200, Y0 = 180, IMG_W = 240, IMG_H = 120;

  logic        Clk = 1'b0;
  logic        Reset_n, game_over, restart, vs, active_video;
  logic [9:0]  DrawX, DrawY;
  logic [3:0]  bg_red, bg_green, bg_blue;
  logic [14:0] rom_addr;
  logic [3:0]  rom_q = 4'h0;
  logic [3:0]  pal_index, pal_red, pal_green, pal_blue;
  logic [3:0]  red, green, blue;
  logic        overlay_active;
  logic [4:0]  fade_level;

  game_over_overlay_ctrl #(.FADE_FRAMES(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .game_over(game_over), .restart(restart), .vs(vs),
    .active_video(active_video), .DrawX(DrawX), .DrawY(DrawY),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue),
    .overlay_active(overlay_active), .fade_level(fade_level)
  );

  always #5 Clk = ~Clk;

  // Image ROM holds the low nibble of its address; palette entry 0 is 9,8,7, all others white.
  always @(posedge Clk) rom_q <= rom_addr[3:0];
  always_comb {pal_red, pal_green, pal_blue} = (pal_index == 4'h0) ? 12'h987 : 12'hFFF;

`ifdef GAME_OVER_OVERLAY_TRANSPARENCY_EN
  localparam logic [15:0] TRANSP_EXP = 16'h0246;
`else
  localparam logic [15:0] TRANSP_EXP = 16'h0987;
`endif

  typedef struct {
    int          due;
    int          kind;   // 0 rgb, 1 rom_addr, 2 fade_level, 3 overlay_active
    logic [15:0] exp;
    string       name;
  } chk_t;

  chk_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [15:0] act_v;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        case (sb[i].kind)
          0:       act_v = {4'h0, red, green, blue};
          1:       act_v = {1'b0, rom_addr};
          2:       act_v = {11'h0, fade_level};
          default: act_v = {15'h0, overlay_active};
        endcase
        checks = checks + 1;
        if (sb[i].due != cyc || act_v !== sb[i].exp) begin
          errors = errors + 1;
          $display("FAIL %s: got %h expected %h (due cycle %0d, checked %0d)",
                   sb[i].name, act_v, sb[i].exp, sb[i].due, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic check_now(input logic [15:0] act, input logic [15:0] exp, input string name);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [15:0] exp, input int ofs, input string name);
    chk_t c;
    c.due  = cyc + ofs;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic frame_tick(input int lvl, input logic ovl, input string name);
    vs = 1'b1;
    step(1);
    push(2, 16'(lvl), 0, name);
    push(3, {15'h0, ovl}, 0, name);
    vs = 1'b0;
    step(2);
  endtask

  task automatic pix(input int x, input int y, input logic [11:0] bg, input logic av,
                     input logic [15:0] exp_addr, input logic [15:0] exp_rgb, input string name);
    DrawX = 10'(x);
    DrawY = 10'(y);
    {bg_red, bg_green, bg_blue} = bg;
    active_video = av;
    push(1, exp_addr, 1, {name, "_addr"});
    push(0, exp_rgb, 3, {name, "_rgb"});
    step(1);
  endtask

  task automatic idle();
    active_video = 1'b0;
    DrawX = '0;
    DrawY = '0;
    {bg_red, bg_green, bg_blue} = 12'h000;
  endtask

  task automatic reset_checks(input string name);
    check_now({4'h0, red, green, blue}, 16'h0000, {name, "_rgb"});
    check_now({1'b0, rom_addr}, 16'h0000, {name, "_addr"});
    check_now({11'h0, fade_level}, 16'h0000, {name, "_level"});
    check_now({15'h0, overlay_active}, 16'h0000, {name, "_ovl"});
  endtask

  initial begin
    Reset_n = 1'b0; game_over = 1'b0; restart = 1'b0; vs = 1'b0;
    active_video = 1'b1; DrawX = 10'(X0 + 3); DrawY = 10'(Y0 + 1);
    {bg_red, bg_green, bg_blue} = 12'h5A5;
    step(4);
    reset_checks("reset");
    Reset_n = 1'b1;
    idle();
    step(2);

    // Fade in one level per frame, then saturate while shown.
    game_over = 1'b1;
    step(1);
    push(3, 16'h1, 0, "enter_fade_in");
    push(2, 16'h0, 0, "enter_fade_in_level");
    step(1);
    for (int i = 1; i <= 16; i++) frame_tick(i, 1'b1, "fade_in");
    frame_tick(16, 1'b1, "shown_sat");

    pix(X0 + 3, Y0 + 1, 12'h000, 1'b1, 16'd243, 16'h0FFF, "lat_l16");
    pix(X0 + IMG_W, Y0 + 1, 12'hA53, 1'b1, 16'd0, 16'h0A53, "win_edge");
    pix(X0 + IMG_W, Y0 + 1, 12'hA53, 1'b0, 16'd0, 16'h0000, "av_off");
    pix(X0, Y0, 12'h246, 1'b1, 16'd0, TRANSP_EXP, "transp");
    pix(X0 + IMG_W - 1, Y0 + IMG_H - 1, 12'h123, 1'b1, 16'd28799, 16'h0FFF, "last_px");
    pix(X0 - 1, Y0, 12'h3C1, 1'b1, 16'd0, 16'h03C1, "left_edge");
    idle();
    step(4);

    // Fade out to half level and check the blend arithmetic there.
    game_over = 1'b0;
    step(1);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(1);
    for (int i = 15; i >= 8; i--) frame_tick(i, 1'b1, "fade_out");
    pix(X0 + 3, Y0 + 1, 12'h000, 1'b1, 16'd243, 16'h0777, "lat_l8");
    pix(X0 + 3, Y0 + 1, 12'hA40, 1'b1, 16'd243, 16'h0C97, "blend_l8");
    idle();
    step(4);
    for (int i = 7; i >= 1; i--) frame_tick(i, 1'b1, "fade_out_low");
    frame_tick(0, 1'b0, "hidden");
    frame_tick(0, 1'b0, "hidden_idle");

    // Reverse a fade-in at level 5.
    game_over = 1'b1;
    step(1);
    game_over = 1'b0;
    step(1);
    for (int i = 1; i <= 5; i++) frame_tick(i, 1'b1, "rev_in");
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    step(1);
    for (int i = 4; i >= 1; i--) frame_tick(i, 1'b1, "rev_out");
    frame_tick(0, 1'b0, "rev_hidden");

    // restart and game_over together while shown: restart wins.
    game_over = 1'b1;
    step(1);
    game_over = 1'b0;
    step(1);
    for (int i = 1; i <= 16; i++) frame_tick(i, 1'b1, "refade_in");
    game_over = 1'b1;
    restart = 1'b1;
    step(1);
    game_over = 1'b0;
    restart = 1'b0;
    step(1);
    frame_tick(15, 1'b1, "both_out");

    // Reset in the middle of a fade-in at level 7 with pixels flowing.
    Reset_n = 1'b0;
    step(1);
    Reset_n = 1'b1;
    step(1);
    game_over = 1'b1;
    step(1);
    game_over = 1'b0;
    step(1);
    for (int i = 1; i <= 7; i++) frame_tick(i, 1'b1, "mid_in");
    active_video = 1'b1;
    DrawX = 10'(X0 + 3);
    DrawY = 10'(Y0 + 1);
    {bg_red, bg_green, bg_blue} = 12'h842;
    step(4);
    Reset_n = 1'b0;
    step(4);
    reset_checks("mid_reset");
    Reset_n = 1'b1;
    idle();
    step(1);
    frame_tick(0, 1'b0, "post_reset");

    step(8);
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard: %0d expectations never checked", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
